// File: rtl/program_loader.sv
// Byte-stream program loader: packs bytes MSB-first into 32-bit words and
// issues single-cycle writes to the program memory write port.
module program_loader #(
    parameter int unsigned MEMORY_DEPTH = 32,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned BASE_ADDRESS = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Start,
    input  logic [15:0]           Length,
    input  logic                  Abort,
    input  logic [7:0]            ByteIn,
    input  logic                  ByteValid,
    output logic                  ByteReady,
    output logic                  WriteEnable,
    output logic [DATA_WIDTH-1:0] WriteAddress,
    output logic [DATA_WIDTH-1:0] WriteData,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Error
);

    typedef enum logic [2:0] {
        StIdle,
        StReceive,
        StWrite,
        StDone,
        StError
    } state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] asm_q, asm_d;
    logic [1:0]            cnt_q, cnt_d;
    logic [15:0]           words_q, words_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;

    logic                  len_bad;
    logic [DATA_WIDTH-1:0] asm_next;

    assign len_bad  = (Length == 16'd0) || (32'(Length) > MEMORY_DEPTH);
    assign asm_next = {asm_q[DATA_WIDTH-9:0], ByteIn};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            asm_q     <= '0;
            cnt_q     <= '0;
            words_q   <= '0;
            addr_q    <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            asm_q     <= asm_d;
            cnt_q     <= cnt_d;
            words_q   <= words_d;
            addr_q    <= addr_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        asm_d     = asm_q;
        cnt_d     = cnt_q;
        words_d   = words_q;
        addr_d    = addr_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        if (Abort) begin
            // Partial word is discarded; a write already on the port completes this cycle.
            state_d = StIdle;
            asm_d   = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle, StDone, StError: begin
                    if (Start) begin
                        if (len_bad) begin
                            state_d = StError;
                        end else begin
                            state_d = StReceive;
                            words_d = Length;
                            addr_d  = DATA_WIDTH'(BASE_ADDRESS);
                            cnt_d   = '0;
                            asm_d   = '0;
                        end
                    end
                end
                StReceive: begin
                    if (ByteValid) begin
                        asm_d = asm_next;
                        cnt_d = cnt_q + 2'd1;
                        if (cnt_q == 2'd3) begin
                            state_d   = StWrite;
                            wr_addr_d = addr_q;
                            wr_data_d = asm_next;
                        end
                    end
                end
                StWrite: begin
                    addr_d  = addr_q + DATA_WIDTH'(4);
                    words_d = words_q - 16'd1;
                    state_d = (words_q == 16'd1) ? StDone : StReceive;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Abort also gates ready so no byte is consumed in the cancel cycle.
    assign ByteReady    = (state_q == StReceive) && !Abort;
    assign WriteEnable  = (state_q == StWrite);
    assign WriteAddress = wr_addr_q;
    assign WriteData    = wr_data_q;
    assign Busy         = (state_q == StReceive) || (state_q == StWrite);
    assign Done         = (state_q == StDone);
    assign Error        = (state_q == StError);

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: expected writes are queued by the
// stimulus and popped by an independent write-port monitor.
module tb_program_loader;

    logic        clk;
    logic        reset;
    logic        Start;
    logic [15:0] Length;
    logic        Abort;
    logic [7:0]  ByteIn;
    logic        ByteValid;
    logic        ByteReady;
    logic        WriteEnable;
    logic [31:0] WriteAddress;
    logic [31:0] WriteData;
    logic        Busy;
    logic        Done;
    logic        Error;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];

    program_loader #(
        .MEMORY_DEPTH(32),
        .DATA_WIDTH  (32),
        .BASE_ADDRESS(0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .Start       (Start),
        .Length      (Length),
        .Abort       (Abort),
        .ByteIn      (ByteIn),
        .ByteValid   (ByteValid),
        .ByteReady   (ByteReady),
        .WriteEnable (WriteEnable),
        .WriteAddress(WriteAddress),
        .WriteData   (WriteData),
        .Busy        (Busy),
        .Done        (Done),
        .Error       (Error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Write-port monitor
    always @(negedge clk) begin
        if (reset === 1'b1 && WriteEnable === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr 0x%08h data 0x%08h, none expected",
                         WriteAddress, WriteData);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                chk("write_addr", WriteAddress, e[63:32]);
                chk("write_data", WriteData, e[31:0]);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [15:0] len);
        Start  = 1'b1;
        Length = len;
        cyc();
        Start  = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic got;
        got       = 1'b0;
        ByteIn    = b;
        ByteValid = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (ByteReady) got = 1'b1;
            cyc();
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL byte_accept_timeout: byte 0x%02h not accepted in 20 cycles", b);
        end
    endtask

    task automatic send_word(input logic [31:0] word, input logic [31:0] addr, input int gap);
        for (int k = 0; k < 4; k++) begin
            if (k == 3) exp_q.push_back({addr, word});
            send_byte(word[31-8*k -: 8]);
            if (k < 3 && gap > 0) begin
                ByteValid = 1'b0;
                repeat (gap) cyc();
            end
        end
        ByteValid = 1'b0;
        chk("write_latency", {31'd0, WriteEnable}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; Start = 1'b0; Length = '0; Abort = 1'b0;
        ByteIn = '0; ByteValid = 1'b0;
        repeat (3) cyc();
        chk("reset_busy", {31'd0, Busy}, 32'd0);
        chk("reset_ready", {31'd0, ByteReady}, 32'd0);
        chk("reset_waddr", WriteAddress, 32'd0);
        chk("reset_wdata", WriteData, 32'd0);
        reset = 1'b1;
        cyc();

        // Basic load, valid held high
        start(16'd2);
        chk("basic_busy", {31'd0, Busy}, 32'd1);
        send_word(32'h20080005, 32'h0, 0);
        send_word(32'h2009000A, 32'h4, 0);
        cyc();
        chk("basic_done", {31'd0, Done}, 32'd1);
        chk("basic_idle_busy", {31'd0, Busy}, 32'd0);
        chk("basic_we_low", {31'd0, WriteEnable}, 32'd0);

        // Gaps between bytes
        start(16'd1);
        chk("gap_done_cleared", {31'd0, Done}, 32'd0);
        send_word(32'h8C090004, 32'h0, 3);
        cyc();
        chk("gap_done", {31'd0, Done}, 32'd1);

        // Illegal lengths
        start(16'd0);
        chk("len0_error", {31'd0, Error}, 32'd1);
        chk("len0_ready", {31'd0, ByteReady}, 32'd0);
        start(16'd33);
        chk("len33_error", {31'd0, Error}, 32'd1);
        chk("len33_busy", {31'd0, Busy}, 32'd0);
        ByteValid = 1'b1;
        repeat (4) cyc();
        ByteValid = 1'b0;
        start(16'd1);
        chk("error_cleared", {31'd0, Error}, 32'd0);
        send_word(32'hCAFEF00D, 32'h0, 0);
        cyc();

        // Abort mid-word
        start(16'd2);
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        Abort = 1'b1; Start = 1'b1; Length = 16'd1; ByteValid = 1'b1; ByteIn = 8'hDD;
        cyc();
        Abort = 1'b0; Start = 1'b0; ByteValid = 1'b0;
        chk("abort_busy", {31'd0, Busy}, 32'd0);
        chk("abort_ready", {31'd0, ByteReady}, 32'd0);
        chk("abort_done", {31'd0, Done}, 32'd0);
        cyc();
        start(16'd1);
        send_word(32'h11223344, 32'h0, 0);
        cyc();
        chk("abort_reload_done", {31'd0, Done}, 32'd1);

        // Full depth
        start(16'd32);
        for (int w = 0; w < 32; w++) begin
            logic [7:0] wb;
            wb = 8'(w);
            send_word({wb, 8'hA5, wb ^ 8'h5A, 8'(w * 3)}, 32'(w * 4), 0);
        end
        cyc();
        chk("full_done", {31'd0, Done}, 32'd1);
        repeat (3) cyc();
        chk("full_queue_empty", 32'(exp_q.size()), 32'd0);

        // Async reset mid-load
        start(16'd2);
        send_byte(8'h01);
        send_byte(8'h02);
        #3;
        reset = 1'b0;
        #1;
        chk("areset_busy", {31'd0, Busy}, 32'd0);
        chk("areset_ready", {31'd0, ByteReady}, 32'd0);
        chk("areset_waddr", WriteAddress, 32'd0);
        chk("areset_wdata", WriteData, 32'd0);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        ByteValid = 1'b1;
        ByteIn = 8'h55;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_reset_ready", {31'd0, ByteReady}, 32'd0);
            chk("post_reset_busy", {31'd0, Busy}, 32'd0);
        end
        ByteValid = 1'b0;
        repeat (2) cyc();
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
